// File: rtl/tt_dfd_fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// tt_dfd_fifo_wr_arbiter_if
// Bundles the requester handshake, the FIFO push lanes and the FIFO feedback
// seen by the trace-FIFO write arbiter.
//   slave  : arbiter side (takes requests/pops/clear, drives ready/push/credits)
//   master : environment side (requesters + FIFO)
// Signals:
//   i_req_valid  [NUM_REQ]             requester has an entry
//   i_req_data   [NUM_REQ*DATA_WIDTH]  requester payloads
//   o_req_ready  [NUM_REQ]             grant (transfer on valid&&ready)
//   o_fifo_psh   [NUM_WR]              registered push lanes
//   o_fifo_data  [NUM_WR*DATA_WIDTH]   registered push data
//   i_fifo_pop   [NUM_RD]              copy of the FIFO pop vector
//   i_fifo_clear                       OR of the FIFO clear vector
//   o_credits    [ADDR_SIZE+1]         free-entry credit count
//   o_stall_cnt  [16]                  backpressure counter
// -----------------------------------------------------------------------------
interface tt_dfd_fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ENTRIES    = 8,
  parameter int NUM_REQ    = 4,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2
);
  localparam int ADDR_SIZE = (ENTRIES == 1) ? 1 : $clog2(ENTRIES);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_WR-1:0]             o_fifo_psh;
  logic [NUM_WR*DATA_WIDTH-1:0]  o_fifo_data;
  logic [NUM_RD-1:0]             i_fifo_pop;
  logic                          i_fifo_clear;
  logic [ADDR_SIZE:0]            o_credits;
  logic [15:0]                   o_stall_cnt;

  modport slave (
    input  i_req_valid, i_req_data, i_fifo_pop, i_fifo_clear,
    output o_req_ready, o_fifo_psh, o_fifo_data, o_credits, o_stall_cnt
  );

  modport master (
    output i_req_valid, i_req_data, i_fifo_pop, i_fifo_clear,
    input  o_req_ready, o_fifo_psh, o_fifo_data, o_credits, o_stall_cnt
  );
endinterface

// File: rtl/tt_dfd_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tt_dfd_fifo_wr_arbiter
// Round-robin write scheduler in front of the multi-push trace FIFO. Each cycle
// up to NUM_WR valid requesters are granted, scanning from rr_ptr upward, and
// the winners are packed onto push lanes 0..k-1 of a registered push stage.
// A local free-entry credit count is decremented at the handshake, so entries
// still sitting in the push stage are already reserved and the FIFO can never
// overflow.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus (slave)    : requester handshake, push lanes, pop/clear feedback,
//                    credits and stall counter (see tt_dfd_fifo_wr_arbiter_if)
// Optional feature macro: TT_DFD_FIFO_ARB_STALL_CNT_EN
//   defined   -> o_stall_cnt counts cycles where some valid requester lost
//                (saturating 16 bits, cleared by reset and by FIFO clear)
//   undefined -> o_stall_cnt tied to zero, no counter flops
// -----------------------------------------------------------------------------
module tt_dfd_fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ENTRIES    = 8,
  parameter int NUM_REQ    = 4,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2
) (
  input logic                      i_clk,
  input logic                      i_reset,
  tt_dfd_fifo_wr_arbiter_if.slave  bus
);
  localparam int ADDR_SIZE = (ENTRIES == 1) ? 1 : $clog2(ENTRIES);
  localparam int CRED_W    = ADDR_SIZE + 1;
  localparam int PTR_W     = $clog2(NUM_REQ);
  localparam int RDATA_W   = NUM_REQ * DATA_WIDTH;

  logic [CRED_W-1:0]            credits;
  logic [CRED_W-1:0]            credits_nxt;
  logic [PTR_W-1:0]             rr_ptr;
  logic [PTR_W-1:0]             rr_ptr_nxt;
  logic [NUM_WR-1:0]            fifo_psh;
  logic [NUM_WR*DATA_WIDTH-1:0] fifo_data;

  logic [NUM_REQ-1:0]           rot_valid;
  logic [RDATA_W-1:0]           rot_data;
  logic [NUM_REQ-1:0]           rot_grant;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_WR-1:0]            lane_vld;
  logic [NUM_WR*DATA_WIDTH-1:0] lane_data;
  logic [CRED_W-1:0]            grant_cnt;
  logic [CRED_W-1:0]            pop_cnt;
  int                           scan_cnt;
  int                           scan_lim;
  int                           scan_last;
  int                           nxt_ptr;

  // Rotate requests so that index 0 is the requester at rr_ptr; this turns the
  // wrapping round-robin scan into a plain low-to-high scan.
  always_comb begin
    rot_valid = NUM_REQ'({bus.i_req_valid, bus.i_req_valid} >> rr_ptr);
    rot_data  = RDATA_W'({bus.i_req_data, bus.i_req_data} >> (int'(rr_ptr) * DATA_WIDTH));
  end

  // Grant the first min(NUM_WR, credits, #valid) rotated requesters and pack
  // them onto the lowest lanes; clear suppresses every grant.
  always_comb begin
    rot_grant = '0;
    lane_vld  = '0;
    lane_data = '0;
    scan_cnt  = 0;
    scan_last = 0;
    if (bus.i_fifo_clear) begin
      scan_lim = 0;
    end else if (credits < CRED_W'(NUM_WR)) begin
      scan_lim = int'(credits);
    end else begin
      scan_lim = NUM_WR;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rot_valid[k] && (scan_cnt < scan_lim)) begin
        rot_grant[k] = 1'b1;
        for (int l = 0; l < NUM_WR; l++) begin
          if (l == scan_cnt) begin
            lane_vld[l] = 1'b1;
            lane_data[l*DATA_WIDTH +: DATA_WIDTH] = rot_data[k*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            lane_vld[l] = lane_vld[l];
          end
        end
        scan_last = k;
        scan_cnt  = scan_cnt + 1;
      end else begin
        rot_grant[k] = rot_grant[k];
      end
    end
    grant_cnt = CRED_W'(scan_cnt);
  end

  // Map rotated grants back to requester indices and advance the pointer to
  // one past the last winner (held when nothing was granted).
  always_comb begin
    grant   = NUM_REQ'(({rot_grant, rot_grant} << rr_ptr) >> NUM_REQ);
    nxt_ptr = int'(rr_ptr) + scan_last + 1;
    if (nxt_ptr >= NUM_REQ) begin
      nxt_ptr = nxt_ptr - NUM_REQ;
    end else begin
      nxt_ptr = nxt_ptr;
    end
    if (scan_cnt != 0) begin
      rr_ptr_nxt = PTR_W'(nxt_ptr);
    end else begin
      rr_ptr_nxt = rr_ptr;
    end
  end

  // Credit update: grants reserve entries now, pops return them a cycle late.
  always_comb begin
    pop_cnt = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      pop_cnt = pop_cnt + CRED_W'(bus.i_fifo_pop[r]);
    end
    credits_nxt = credits - grant_cnt + pop_cnt;
  end

  // Push stage, credits and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fifo_psh  <= '0;
      fifo_data <= '0;
      credits   <= CRED_W'(ENTRIES);
      rr_ptr    <= '0;
    end else if (bus.i_fifo_clear) begin
      // The FIFO drops pushes on clear, so the push stage is emptied too.
      fifo_psh <= '0;
      credits  <= CRED_W'(ENTRIES);
    end else begin
      fifo_psh <= lane_vld;
      for (int l = 0; l < NUM_WR; l++) begin
        if (lane_vld[l]) begin
          fifo_data[l*DATA_WIDTH +: DATA_WIDTH] <= lane_data[l*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      credits <= credits_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_fifo_psh  = fifo_psh;
  assign bus.o_fifo_data = fifo_data;
  assign bus.o_credits   = credits;

`ifdef TT_DFD_FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int          valid_cnt;
  logic        stall_hit;

  // A stall cycle is one where at least one valid requester was not granted.
  always_comb begin
    valid_cnt = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      valid_cnt = valid_cnt + int'(bus.i_req_valid[k]);
    end
    stall_hit = (valid_cnt != 0) && (scan_cnt < valid_cnt);
  end

  // Saturating backpressure counter, cleared together with the FIFO.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt <= 16'h0000;
    end else if (bus.i_fifo_clear) begin
      stall_cnt <= 16'h0000;
    end else if (stall_hit && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

  assign bus.o_stall_cnt = stall_cnt;
`else
  assign bus.o_stall_cnt = 16'h0000;
`endif

  tt_dfd_fifo_wr_arbiter_chk #(
    .CRED_W  (CRED_W),
    .ENTRIES (ENTRIES)
  ) u_chk (
    .clk     (i_clk),
    .rst     (i_reset),
    .credits (credits)
  );
endmodule

// -----------------------------------------------------------------------------
// tt_dfd_fifo_wr_arbiter_chk
// Property checker: the credit count can never exceed the FIFO depth (a pop
// reported for an entry that was never pushed would break this).
// Ports: clk, rst (active-high), credits (observed credit count)
// -----------------------------------------------------------------------------
module tt_dfd_fifo_wr_arbiter_chk #(
  parameter int CRED_W  = 4,
  parameter int ENTRIES = 8
) (
  input logic              clk,
  input logic              rst,
  input logic [CRED_W-1:0] credits
);
  a_credit_bound: assert property (@(posedge clk) disable iff (rst) credits <= CRED_W'(ENTRIES));
endmodule

// File: tb/tb_tt_dfd_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for tt_dfd_fifo_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based round-robin model and a model of the FIFO occupancy behind it.
// -----------------------------------------------------------------------------
module tb_tt_dfd_fifo_wr_arbiter;
  localparam int DW = 4;
  localparam int EN = 8;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_dfd_fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .ENTRIES(EN), .NUM_REQ(NR), .NUM_WR(NW), .NUM_RD(ND)) bus ();

  tt_dfd_fifo_wr_arbiter #(.DATA_WIDTH(DW), .ENTRIES(EN), .NUM_REQ(NR), .NUM_WR(NW), .NUM_RD(ND)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state (current and next).
  int               m_cred, m_rr, m_stall, m_occ;
  logic [NW-1:0]    m_psh;
  logic [DW-1:0]    m_data [NW];
  int               n_cred, n_rr, n_stall, n_occ;
  logic [NW-1:0]    n_psh;
  logic [DW-1:0]    n_data [NW];

  // Compare the DUT against the model and compute the model's next state.
  always @(negedge clk) begin : cmp
    int q[$];
    int g, lim, np, idx, exp_stall;
    logic [NR-1:0] er;
    if (rst) begin
      n_cred = EN; n_rr = 0; n_stall = 0; n_occ = 0; n_psh = '0;
      for (int l = 0; l < NW; l++) n_data[l] = '0;
    end else begin
      q.delete();
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (bus.i_req_valid[idx]) q.push_back(idx);
      end
      lim = (m_cred < NW) ? m_cred : NW;
      g = bus.i_fifo_clear ? 0 : ((q.size() < lim) ? q.size() : lim);
      er = '0;
      for (int n = 0; n < g; n++) er[q[n]] = 1'b1;
`ifdef TT_DFD_FIFO_ARB_STALL_CNT_EN
      exp_stall = m_stall;
`else
      exp_stall = 0;
`endif
      chk("ready", bus.o_req_ready, er);
      chk("psh", bus.o_fifo_psh, m_psh);
      for (int l = 0; l < NW; l++)
        if (m_psh[l]) chk("data", bus.o_fifo_data[l*DW +: DW], m_data[l]);
      chk("credits", bus.o_credits, m_cred);
      chk("stall", bus.o_stall_cnt, exp_stall);
      // Occupancy of the FIFO fed by the DUT's own push lanes.
      chk("credit_vs_occ", bus.o_credits, EN - m_occ - $countones(bus.o_fifo_psh));
      chk("fifo_no_overflow", (m_occ <= EN), 1);

      np = $countones(bus.i_fifo_pop);
      n_data = m_data;
      if (bus.i_fifo_clear) begin
        n_cred = EN; n_psh = '0; n_rr = m_rr; n_stall = 0; n_occ = 0;
      end else begin
        n_cred = m_cred - g + np;
        n_psh  = '0;
        for (int n = 0; n < g; n++) begin
          n_psh[n]  = 1'b1;
          n_data[n] = bus.i_req_data[q[n]*DW +: DW];
        end
        n_rr    = (g > 0) ? (q[g-1] + 1) % NR : m_rr;
        n_stall = (q.size() > 0 && g < q.size() && m_stall < 65535) ? m_stall + 1 : m_stall;
        n_occ   = m_occ - np + $countones(bus.o_fifo_psh);
      end
    end
  end

  // Commit the model state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cred <= EN; m_rr <= 0; m_stall <= 0; m_occ <= 0; m_psh <= '0;
      for (int l = 0; l < NW; l++) m_data[l] <= '0;
    end else begin
      m_cred <= n_cred; m_rr <= n_rr; m_stall <= n_stall; m_occ <= n_occ; m_psh <= n_psh;
      for (int l = 0; l < NW; l++) m_data[l] <= n_data[l];
    end
  end

  task automatic drive(input logic [NR-1:0] v, input logic [ND-1:0] p, input logic c);
    bus.i_req_valid  = v;
    bus.i_fifo_pop   = p;
    bus.i_fifo_clear = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int maxp, np;
    rst = 1'b1;
    bus.i_req_data = 16'h8765;   // req3=8 req2=7 req1=6 req0=5
    drive(4'b0000, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_ready", bus.o_req_ready, 4'b0000);
    chk("rst_psh", bus.o_fifo_psh, 2'b00);
    chk("rst_data", bus.o_fifo_data, 8'h00);
    chk("rst_credits", bus.o_credits, 4'd8);
    chk("rst_stall", bus.o_stall_cnt, 16'h0000);
    tick();

    // All four valid: req0,req1 then req2,req3; credits 8->6->4.
    drive(4'b1111, 2'b00, 1'b0); @(negedge clk);
    chk("c0_ready", bus.o_req_ready, 4'b0011);
    tick();
    @(negedge clk);
    chk("c1_psh", bus.o_fifo_psh, 2'b11);
    chk("c1_data", bus.o_fifo_data, 8'h65);
    chk("c1_credits", bus.o_credits, 4'd6);
    chk("c1_ready", bus.o_req_ready, 4'b1100);
    tick();

    // Only req1 -> rr_ptr becomes 2.
    drive(4'b0010, 2'b00, 1'b0); @(negedge clk);
    chk("c2_data", bus.o_fifo_data, 8'h87);
    chk("c2_credits", bus.o_credits, 4'd4);
    chk("c2_ready", bus.o_req_ready, 4'b0010);
    tick();

    // req3 and req0 with rr_ptr=2: lane0=req3, lane1=req0.
    drive(4'b1001, 2'b00, 1'b0); @(negedge clk);
    chk("wrap_ready", bus.o_req_ready, 4'b1001);
    chk("wrap_credits", bus.o_credits, 4'd3);
    tick();

    // credits=1 with three valid, rr_ptr=1: single grant of req1 on lane0.
    drive(4'b0111, 2'b00, 1'b0); @(negedge clk);
    chk("wrap_data", bus.o_fifo_data, 8'h58);
    chk("part_credits", bus.o_credits, 4'd1);
    chk("part_ready", bus.o_req_ready, 4'b0010);
    tick();
    @(negedge clk);
    chk("full_credits", bus.o_credits, 4'd0);
    chk("full_ready", bus.o_req_ready, 4'b0000);
    chk("part_psh", bus.o_fifo_psh, 2'b01);
    chk("part_data", bus.o_fifo_data[3:0], 4'h6);
    tick();

    // Pop 2 -> credits 2, then pop 1 -> 3.
    drive(4'b0000, 2'b11, 1'b0); tick();
    drive(4'b0000, 2'b01, 1'b0); @(negedge clk);
    chk("pop_ret", bus.o_credits, 4'd2);
    tick();

    // Grant 2 and pop 2 at credits=3 -> stays 3.
    drive(4'b1100, 2'b11, 1'b0); @(negedge clk);
    chk("gp_credits", bus.o_credits, 4'd3);
    chk("gp_ready", bus.o_req_ready, 4'b1100);
    tick();

    // Clear with two pushes pending.
    drive(4'b1111, 2'b00, 1'b1); @(negedge clk);
    chk("clr_ready", bus.o_req_ready, 4'b0000);
    chk("clr_pend_psh", bus.o_fifo_psh, 2'b11);
    tick();
    drive(4'b0000, 2'b00, 1'b0); @(negedge clk);
    chk("clr_psh", bus.o_fifo_psh, 2'b00);
    chk("clr_credits", bus.o_credits, 4'd8);
    tick();

    // Exhaust credits with two requesters, then hold them at credits=0.
    repeat (4) begin drive(4'b0011, 2'b00, 1'b0); tick(); end
    repeat (5) begin
      drive(4'b0011, 2'b00, 1'b0); @(negedge clk);
      chk("hold_credits", bus.o_credits, 4'd0);
      tick();
    end
    drive(4'b0000, 2'b00, 1'b0); @(negedge clk);
`ifdef TT_DFD_FIFO_ARB_STALL_CNT_EN
    chk("stall_five", bus.o_stall_cnt, 16'd5);
`else
    chk("stall_tied", bus.o_stall_cnt, 16'd0);
`endif
    tick();
    drive(4'b0000, 2'b00, 1'b1); tick();
    drive(4'b0000, 2'b00, 1'b0); @(negedge clk);
    chk("stall_clr", bus.o_stall_cnt, 16'd0);
    tick();

    // Randomized traffic with phases of sparse pops and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        drive(4'b0000, 2'b00, 1'b0);
        tick(); tick();
        rst = 1'b0;
      end
      bus.i_req_data = 16'($urandom);
      maxp = (m_occ < ND) ? m_occ : ND;
      if (((i / 200) % 2) == 1 && $urandom_range(0, 3) != 0) np = 0;
      else np = $urandom_range(0, maxp);
      drive(4'($urandom_range(0, 15)), 2'((1 << np) - 1), ($urandom_range(0, 39) == 0));
      tick();
    end
    drive(4'b0000, 2'b00, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
